kyber_server_link: RTL

KYBER_SERVER_LINK -- requirements
Module: kyber_server_link

---
 rtl/kyber_server_link_if.sv | 27 ++
 rtl/kyber_server_link.sv | 81 ++++++++
 2 files changed

// File: rtl/kyber_server_link_if.sv
// kyber_server_link_if: client, pk-buffer and ct-buffer signals of the Kyber server link
interface kyber_server_link_if #(parameter int AW = 9);
    logic          start;
    logic [2:0]    k;
    logic          req_pk;
    logic          req_c;
    logic          wen;
    logic [31:0]   din;
    logic [AW-1:0] pk_addr;
    logic [31:0]   pk_rdata;
    logic          ct_we;
    logic [AW-1:0] ct_addr;
    logic [31:0]   ct_wdata;
    logic          valid;
    logic [31:0]   dout;
    logic          busy;
    logic          done;
    logic          err;
    modport master (
        output start, k, req_pk, req_c, wen, din, pk_rdata,
        input  pk_addr, ct_we, ct_addr, ct_wdata, valid, dout, busy, done, err
    );
    modport slave (
        input  start, k, req_pk, req_c, wen, din, pk_rdata,
        output pk_addr, ct_we, ct_addr, ct_wdata, valid, dout, busy, done, err
    );
endinterface

// File: rtl/kyber_server_link.sv
// kyber_server_link: streams the public key to a client and collects its ciphertext into a buffer
module kyber_server_link #(
    parameter int AW = 9
) (
    input logic clk,
    input logic rst,
    kyber_server_link_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT_PK, SEND, WAIT_C, RECV, DONE} state_t;
    state_t     state;
    logic [2:0] k_q;
    logic [8:0] cnt;
    logic [8:0] pa;
    logic [8:0] npk_m1;
    logic [8:0] nc_m1;
    logic       err_q;
    logic       legal;
    logic       accept;
    assign legal  = bus.k inside {3'd2, 3'd3, 3'd4};
    assign npk_m1 = k_q == 3'd2 ? 9'd199 : k_q == 3'd3 ? 9'd295 : 9'd391;
    assign nc_m1  = k_q == 3'd2 ? 9'd191 : k_q == 3'd3 ? 9'd271 : 9'd391;
    assign accept = rst && bus.wen && (state == WAIT_C || state == RECV);
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            k_q   <= '0;
            cnt   <= '0;
            pa    <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    if (legal) begin
                        k_q   <= bus.k;
                        err_q <= 1'b0;
                        cnt   <= '0;
                        pa    <= '0;
                        state <= WAIT_PK;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                // pa runs one ahead of the word on dout to cover the buffer read latency
                WAIT_PK: if (bus.req_pk) begin
                    pa    <= 9'd1;
                    cnt   <= '0;
                    state <= SEND;
                end
                SEND: begin
                    cnt <= cnt + 9'd1;
                    if (pa != npk_m1) pa <= pa + 9'd1;
                    if (cnt == npk_m1) begin
                        cnt   <= '0;
                        pa    <= '0;
                        state <= WAIT_C;
                    end
                end
                WAIT_C, RECV: if (bus.wen) begin
                    cnt   <= cnt + 9'd1;
                    state <= cnt == nc_m1 ? DONE : RECV;
                end else if (state == WAIT_C && bus.req_c) begin
                    state <= RECV;
                end
                DONE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.pk_addr  = rst ? AW'(pa) : '0;
    assign bus.valid    = rst && state == SEND;
    assign bus.dout     = bus.valid ? bus.pk_rdata : 32'd0;
    assign bus.ct_we    = accept;
    assign bus.ct_addr  = accept ? AW'(cnt) : '0;
    assign bus.ct_wdata = accept ? bus.din : 32'd0;
    assign bus.busy     = rst && state != IDLE;
    assign bus.done     = rst && state == DONE;
    assign bus.err      = rst && err_q;
endmodule
